ram_bist: RTL and testbench
===========================

Name: ram_bist

Overview:
- Hardware initiator for the ram_if write/read port: a March C- style built-in self-test engine that drives the RAM's write and read channels and checks read data.
- Sits on the master side of the same interface as the ram block, in place of a software or bench driver.
- Started by a single pulse. Reports pass/fail, the first failing address and the captured data.

Parameters:
- D_WIDTH, 32, data width; must match the ram instance.
- A_WIDTH, 5, address width; depth is 2**A_WIDTH.
- RD_LAT, 1, RAM read latency in cycles, range 1..4; read_data is valid RD_LAT edges after read_en is sampled.
- BG, {D_WIDTH{1'b0}}, background data pattern.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid from done; held until the next accepted start.
- fail_addr  out  A_WIDTH  address of the first mismatch.
- fail_data  out  D_WIDTH  read data at the first mismatch.
- err_count  out  8  mismatch count; see Optional Feature.
- write_en  out  1  RAM write strobe.
- write_addr  out  A_WIDTH  RAM write address.
- write_data  out  D_WIDTH  RAM write data.
- read_en  out  1  RAM read strobe.
- read_addr  out  A_WIDTH  RAM read address.
- read_data  in  D_WIDTH  RAM read data.

Behaviour:
- Reset (rst==0 at an edge), all outputs registered:
  - write_en, read_en, busy, done, pass = 0.
  - All addresses, write_data, fail_addr, fail_data, err_count = 0.
  - State = IDLE.
  - Reset mid-test aborts at that edge; no further strobes are issued.
- States: IDLE, E0_W, E1_RW, E2_RW, E3_R, DONE.
  - Each RW/R element is sub-sequenced RD_ISSUE -> WAIT (RD_LAT-1 cycles) -> CHECK.
- E0_W, ascending 0..2**A-1: one write per cycle of BG.
- E1_RW, ascending: per address, read expecting BG; in the CHECK cycle, write ~BG to the same address.
- E2_RW, descending 2**A-1..0: read expecting ~BG; in CHECK, write BG.
- E3_R, ascending: read expecting BG; no write.
- Per-address cost in E1..E3 is RD_LAT+1 cycles.
- Total busy cycles = 2**A + 3*2**A*(RD_LAT+1); this is 224 for the defaults.
- Transitions:
  - IDLE -> E0_W on start.
  - Each element advances after its last address.
  - E3_R -> DONE after its last CHECK.
  - DONE -> IDLE the next cycle. done is high only in DONE.
- start is ignored while busy or in DONE. start on the reset-release edge is ignored.
- Mismatch means read_data != expected in a CHECK cycle.
  - On the first mismatch, capture fail_addr and fail_data.
  - pass = (no mismatch) at DONE.
- read_en and write_en are never both high in the same cycle.
- Address counter wraps with no carry out. The last-address flag comes from counter == 2**A-1 when ascending, or == 0 when descending.

Optional Feature:
- Macro: RAM_BIST_CONTINUE_EN.
- Defined:
  - Mismatches do not stop the test.
  - err_count increments per mismatch and saturates at 255.
  - fail_addr and fail_data hold the first mismatch only.
- Undefined:
  - The first mismatch jumps to DONE at the next edge; the pending write is suppressed.
  - err_count = pass ? 0 : 1.

Decomposition:
- ram_bist_pkg holds:
  - The state_t enum (IDLE, E0_W, E1_RW, E2_RW, E3_R, DONE).
  - The sub_t enum (RD_ISSUE, WAIT, CHECK).
  - The ERR_MAX=255 constant.
- Sub-module ram_bist_addr_gen holds the up/down address counter: load, step, dir, last flag, parameterised by A_WIDTH.

Test Plan:
- Reset held 3 cycles then released, no start -> all outputs 0, no strobes.
- Good ram instance, defaults, start pulse:
  - busy is high exactly 224 cycles, then done=1 for 1 cycle, pass=1, err_count=0.
  - write_en count is 96 and read_en count is 96.
- Bench RAM model with bit 0 of address 5'h10 stuck at 1:
  - pass=0, fail_addr=5'h10, fail_data=32'h1.
  - Without the macro, done arrives early (first CHECK of E1 at address 0x10).
- Same fault with RAM_BIST_CONTINUE_EN: full 224-cycle run; err_count=2, from the E1 and E3 checks of address 0x10.
- rst asserted at cycle 50 of a run -> next edge write_en=read_en=busy=0. A new start completes with pass=1.
- RD_LAT=3 with a matching model -> busy for 32 + 3*32*4 = 416 cycles, pass=1; start pulses during busy are ignored.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the ram_bist March C- engine.
package ram_bist_pkg;

    typedef enum logic [2:0] {IDLE, E0_W, E1_RW, E2_RW, E3_R, DONE} state_t;
    typedef enum logic [1:0] {RD_ISSUE, WAIT, CHECK} sub_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the BIST elements; load picks the start end from dir_i.
module ram_bist_addr_gen #(
    parameter int A_WIDTH = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               dir_i,
    input  logic               step_i,
    output logic [A_WIDTH-1:0] addr_o,
    output logic               last_o
);

    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (load_i) begin
            cnt_d = dir_i ? '1 : '0;
            dir_d = dir_i;
        end else if (step_i) begin
            cnt_d = dir_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            dir_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign addr_o = cnt_q;
    assign last_o = dir_q ? (cnt_q == '0) : (cnt_q == '1);

endmodule

// File: rtl/ram_bist.sv
// March C- BIST initiator for the ram_if write/read port.
// RAM_BIST_CONTINUE_EN: run to completion on mismatches and count them (saturating).
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                 D_WIDTH = 32,
    parameter int                 A_WIDTH = 5,
    parameter int                 RD_LAT  = 1,
    parameter logic [D_WIDTH-1:0] BG      = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,          // active low
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [A_WIDTH-1:0] fail_addr_o,
    output logic [D_WIDTH-1:0] fail_data_o,
    output logic [7:0]         err_count_o,
    output logic               write_en_o,
    output logic [A_WIDTH-1:0] write_addr_o,
    output logic [D_WIDTH-1:0] write_data_o,
    output logic               read_en_o,
    output logic [A_WIDTH-1:0] read_addr_o,
    input  logic [D_WIDTH-1:0] read_data_i
);

`ifdef RAM_BIST_CONTINUE_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    state_t             state_q, state_d;
    sub_t               sub_q, sub_d;
    logic [1:0]         wait_q, wait_d;
    logic [A_WIDTH-1:0] addr;
    logic               last, load, dir, step;
    logic               rw_elem, mism, accept;
    logic [D_WIDTH-1:0] exp_data;
    logic               busy_q, busy_d, done_q, done_d;
    logic               wen_q, wen_d, ren_q, ren_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic               pass_q, seen_q;
    logic [A_WIDTH-1:0] fail_addr_q;
    logic [D_WIDTH-1:0] fail_data_q;
    logic [7:0]         err_q;

    ram_bist_addr_gen #(.A_WIDTH(A_WIDTH)) u_addr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load),
        .dir_i  (dir),
        .step_i (step),
        .addr_o (addr),
        .last_o (last)
    );

    assign rw_elem  = (state_q == E1_RW) || (state_q == E2_RW) || (state_q == E3_R);
    assign exp_data = (state_q == E2_RW) ? ~BG : BG;
    assign mism     = rw_elem && (sub_q == CHECK) && (read_data_i != exp_data);
    assign accept   = (state_q == IDLE) && start_i;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        wait_d  = wait_q;
        load    = 1'b0;
        dir     = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = E0_W;
                sub_d   = RD_ISSUE;
                load    = 1'b1;
            end
            E0_W: begin
                step = 1'b1;
                if (last) begin
                    state_d = E1_RW;
                    load    = 1'b1;
                end
            end
            E1_RW, E2_RW, E3_R: begin
                case (sub_q)
                    RD_ISSUE: begin
                        sub_d  = (RD_LAT == 1) ? CHECK : WAIT;
                        wait_d = 2'(RD_LAT - 2);
                    end
                    WAIT: begin
                        if (wait_q == '0) sub_d = CHECK;
                        else              wait_d = wait_q - 1'b1;
                    end
                    default: begin
                        if (mism && !CONT) begin
                            state_d = DONE;
                        end else begin
                            step  = 1'b1;
                            sub_d = RD_ISSUE;
                            if (last) begin
                                case (state_q)
                                    E1_RW:   begin state_d = E2_RW; load = 1'b1; dir = 1'b1; end
                                    E2_RW:   begin state_d = E3_R;  load = 1'b1; end
                                    default: state_d = DONE;
                                endcase
                            end
                        end
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they line up with state_q.
        busy_d  = (state_d == E0_W) || (state_d == E1_RW) || (state_d == E2_RW) || (state_d == E3_R);
        done_d  = (state_d == DONE);
        ren_d   = busy_d && (state_d != E0_W) && (sub_d == RD_ISSUE);
        wen_d   = (state_d == E0_W) || (((state_d == E1_RW) || (state_d == E2_RW)) && (sub_d == CHECK));
        wdata_d = (state_d == E1_RW) ? ~BG : BG;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            sub_q       <= RD_ISSUE;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            wdata_q     <= '0;
            pass_q      <= 1'b0;
            seen_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_q       <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
            wdata_q <= wdata_d;
            if (accept) begin
                pass_q      <= 1'b0;
                seen_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
                err_q       <= '0;
            end else if (mism) begin
                seen_q <= 1'b1;
                if (!seen_q) begin
                    fail_addr_q <= addr;
                    fail_data_q <= read_data_i;
                end
                if (CONT) err_q <= (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
                else      err_q <= 8'd1;
            end
            if ((state_d == DONE) && (state_q != DONE)) pass_q <= !(seen_q || mism);
        end
    end

    // In stop-on-error mode the write riding in a failing CHECK cycle is dropped.
    assign write_en_o   = wen_q & ~(mism & ~CONT);
    assign read_en_o    = ren_q;
    assign write_addr_o = addr;
    assign read_addr_o  = addr;
    assign write_data_o = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_data_o  = fail_data_q;
    assign err_count_o  = err_q;

endmodule

// File: tb/tb_ram_bist.sv
// Scoreboard bench for ram_bist: RD_LAT=1 instance (with stuck-bit fault option) and RD_LAT=3 instance.
module tb_ram_bist;

    typedef struct {
        string       nm;
        bit          pass;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic [7:0]  ec;
        int          busy;
        int          wr;
        int          rd;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   ntests = 0;
    int   nfail  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start3, fault;

    logic        busy, done, pass, wen, ren;
    logic [4:0]  fa, waddr, raddr;
    logic [31:0] fd, wdata, rdata;
    logic [7:0]  ec;

    logic        busy3, done3, pass3, wen3, ren3;
    logic [4:0]  fa3, waddr3, raddr3;
    logic [31:0] fd3, wdata3, rdata3;
    logic [7:0]  ec3;

    ram_bist #(.D_WIDTH(32), .A_WIDTH(5), .RD_LAT(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_addr_o(fa), .fail_data_o(fd), .err_count_o(ec), .write_en_o(wen), .write_addr_o(waddr),
        .write_data_o(wdata), .read_en_o(ren), .read_addr_o(raddr), .read_data_i(rdata)
    );

    ram_bist #(.D_WIDTH(32), .A_WIDTH(5), .RD_LAT(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .busy_o(busy3), .done_o(done3), .pass_o(pass3),
        .fail_addr_o(fa3), .fail_data_o(fd3), .err_count_o(ec3), .write_en_o(wen3), .write_addr_o(waddr3),
        .write_data_o(wdata3), .read_en_o(ren3), .read_addr_o(raddr3), .read_data_i(rdata3)
    );

    // RAM models: latency 1 with optional bit-0 stuck-at-1 at 0x10; latency 3 clean.
    logic [31:0] mem1 [32];
    logic [31:0] mem3 [32];
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        if (wen) mem1[waddr] <= wdata;
        if (ren) rdata <= mem1[raddr] | ((fault && raddr == 5'h10) ? 32'h1 : 32'h0);
        if (wen3) mem3[waddr3] <= wdata3;
        p3[0] <= mem3[raddr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    int busy_n, wr_n, rd_n, ovl;
    int busy3_n, wr3_n, rd3_n;

    initial begin : mon1
        exp_t e;
        bit   dprev;
        busy_n = 0; wr_n = 0; rd_n = 0; ovl = 0; dprev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_n = 0; wr_n = 0; rd_n = 0; dprev = 0;
            end else begin
                if (busy) busy_n++;
                if (wen)  wr_n++;
                if (ren)  rd_n++;
                if (wen && ren) ovl++;
                if (wen3 && ren3) ovl++;
                if (dprev) chk("done_one_cycle", done, 1'b0);
                if (done) begin
                    chk("q1_has_entry", q1.size() > 0, 1'b1);
                    if (q1.size() > 0) begin
                        e = q1.pop_front();
                        chk({e.nm, "_pass"}, pass, e.pass);
                        chk({e.nm, "_fail_addr"}, fa, e.fa);
                        chk({e.nm, "_fail_data"}, fd, e.fd);
                        chk({e.nm, "_err_count"}, ec, e.ec);
                        chk({e.nm, "_busy_cycles"}, busy_n, e.busy);
                        chk({e.nm, "_writes"}, wr_n, e.wr);
                        chk({e.nm, "_reads"}, rd_n, e.rd);
                    end
                    busy_n = 0; wr_n = 0; rd_n = 0;
                end
                dprev = done;
            end
        end
    end

    initial begin : mon3
        exp_t e;
        busy3_n = 0; wr3_n = 0; rd3_n = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy3_n = 0; wr3_n = 0; rd3_n = 0;
            end else begin
                if (busy3) busy3_n++;
                if (wen3)  wr3_n++;
                if (ren3)  rd3_n++;
                if (done3) begin
                    chk("q3_has_entry", q3.size() > 0, 1'b1);
                    if (q3.size() > 0) begin
                        e = q3.pop_front();
                        chk({e.nm, "_pass"}, pass3, e.pass);
                        chk({e.nm, "_err_count"}, ec3, e.ec);
                        chk({e.nm, "_busy_cycles"}, busy3_n, e.busy);
                        chk({e.nm, "_writes"}, wr3_n, e.wr);
                        chk({e.nm, "_reads"}, rd3_n, e.rd);
                    end
                    busy3_n = 0; wr3_n = 0; rd3_n = 0;
                end
            end
        end
    end

    task automatic pulse1();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done1(input int lim);
        int c = 0;
        while (!done && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    initial begin : stim
        int c;
        rst = 1'b0; start = 1'b0; start3 = 1'b0; fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_wen", wen, 1'b0);
        chk("rst_ren", ren, 1'b0);
        chk("rst_addrs", {waddr, raddr}, 10'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_fail", {fa, fd}, 37'h0);
        chk("rst_err", ec, 8'h0);
        chk("rst_no_strobes", wr_n + rd_n, 0);
        chk("rst3_outs", {busy3, done3, pass3, wen3, ren3}, 5'h0);

        // Clean RAM, stop-on-error and continue builds agree.
        q1.push_back('{"good", 1'b1, 5'h0, 32'h0, 8'd0, 224, 96, 96});
        pulse1();
        wait_done1(1000);
        repeat (3) @(negedge clk);
        chk("pass_held", pass, 1'b1);

        // Bit 0 of address 0x10 stuck at 1.
        fault = 1'b1;
`ifdef RAM_BIST_CONTINUE_EN
        q1.push_back('{"stuck", 1'b0, 5'h10, 32'h1, 8'd2, 224, 96, 96});
`else
        q1.push_back('{"stuck", 1'b0, 5'h10, 32'h1, 8'd1, 66, 48, 17});
`endif
        pulse1();
        wait_done1(1000);
        fault = 1'b0;

        // Abort mid-run by reset, then a clean rerun.
        pulse1();
        repeat (50) @(negedge clk);
        chk("busy_before_abort", busy, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_wen", wen, 1'b0);
        chk("abort_ren", ren, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        q1.push_back('{"rerun", 1'b1, 5'h0, 32'h0, 8'd0, 224, 96, 96});
        pulse1();
        wait_done1(1000);

        // Latency-3 instance with stray start pulses while busy.
        q3.push_back('{"lat3", 1'b1, 5'h0, 32'h0, 8'd0, 416, 96, 96});
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        c = 0;
        while (!done3 && c < 2000) begin
            @(negedge clk);
            start3 = (c == 10 || c == 100 || c == 300);
            c++;
        end
        start3 = 1'b0;
        chk("done3_seen", done3, 1'b1);
        repeat (3) @(negedge clk);
        chk("lat3_idle_after", busy3, 1'b0);

        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);
        chk("rw_exclusive", ovl, 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
